pc_gen_unit: RTL and testbench

Parametrised next-generation PC generator for the RISC-V core's IF stage. It keeps the PC register, selects the next PC, and supports a configurable prediction mode (none, BTB-only, BTB gated by BHT). It adds a return-address stack (RAS) for call/return prediction and a request/grant handshake toward instruction memory. Instruction fetch itself still happens in ID; this block produces the PC, the prediction flag and the fetch request.

---
 rtl/core_pkg.sv | 23 ++
 rtl/return_address_stack.sv | 67 ++++++
 rtl/pc_gen_unit.sv | 153 +++++++++++++++
 tb/tb_pc_gen_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: pc_mux codes, prediction modes, PC helpers
package core_pkg;

    // pc_mux source codes driven by the ID/EX control logic
    localparam logic [3:0] PC_BOOT    = 4'h0;
    localparam logic [3:0] PC_JUMP    = 4'h2;
    localparam logic [3:0] PC_BRANCH  = 4'h3;
    localparam logic [3:0] PC_EX_INCR = 4'h4;
    localparam logic [3:0] PC_RAS     = 4'h5;

    // Branch prediction modes of the IF-stage PC generator
    localparam int PRED_NONE    = 0;
    localparam int PRED_BTB     = 1;
    localparam int PRED_BTB_BHT = 2;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Next sequential instruction address; wraps modulo 2^32
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return-address stack with saturating count
module return_address_stack
    import core_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_addr,
    input  logic        pop,
    input  logic        flush,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop_ok;
    logic [PW-1:0] w_ptr_inc;
    logic [PW-1:0] w_ptr_dec;

    // Popping an empty stack is ignored; pointers wrap because DEPTH is a power of two
    assign w_pop_ok  = pop && (r_count != '0);
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;

    // Stack storage, top pointer and occupancy; full pushes overwrite the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push && w_pop_ok) begin
            r_mem[r_ptr] <= push_addr;
        end else if (push) begin
            r_ptr            <= w_ptr_inc;
            r_mem[w_ptr_inc] <= push_addr;
            if (r_count != COUNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop_ok) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - 1'b1;
        end
    end

    // Status is a pure function of stored state, so a push shows up the next cycle
    always_comb begin
        empty = (r_count == '0);
        full  = (r_count == COUNT_MAX);
        top   = empty ? 32'h0 : r_mem[r_ptr];
    end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - IF-stage PC register, next-PC selection, prediction and RAS
module pc_gen_unit
    import core_pkg::*;
#(
    parameter int          PRED_MODE = 0,
    parameter int          RAS_DEPTH = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] CLEAR_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if_i,
    input  logic        clear_if_i,
    input  logic        pc_set_i,
    input  logic [3:0]  pc_mux_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] jump_target_id_i,
    input  logic [31:0] branch_target_ex_i,
    input  logic [31:0] pc_ex_i,
    input  logic        btb_hit_i,
    input  logic [31:0] btb_target_i,
    input  logic        bht_taken_i,
    input  logic        ras_push_i,
    input  logic [31:0] ras_push_addr_i,
    input  logic        ras_flush_i,
    input  logic        fetch_gnt_i,
    output logic        fetch_req_o,
    output logic [31:0] pc_if_o,
    output logic        branch_prediction_if_o,
    output logic [31:0] ras_top_o,
    output logic        ras_empty_o,
    output logic        ras_full_o
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_incr;
    logic        w_fetch_req;
    logic        w_fetch_fire;
    logic        w_pred_cond;
    logic        w_ras_pop;
    logic [31:0] w_ras_top;
    logic        w_ras_empty;
    logic        w_ras_full;

    assign w_pc_incr    = pc_incr(r_pc);
    assign w_fetch_fire = w_fetch_req && fetch_gnt_i;

    // FSM state register; only rst_n brings the block back to BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // BOOT lasts exactly one cycle after reset release
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    // Fetch request is raised in RUN and dropped while IF is stalled
    always_comb begin
        w_fetch_req = 1'b0;
        case (r_state)
            BOOT:    w_fetch_req = 1'b0;
            RUN:     w_fetch_req = !stall_if_i;
            default: w_fetch_req = 1'b0;
        endcase
    end

    // Prediction condition selected by the elaboration-time prediction mode
    always_comb begin
        w_pred_cond = 1'b0;
        case (PRED_MODE)
            PRED_BTB:     w_pred_cond = btb_hit_i;
            PRED_BTB_BHT: w_pred_cond = btb_hit_i && bht_taken_i;
            default:      w_pred_cond = 1'b0;
        endcase
    end

    // A RAS return only consumes an entry when the redirect actually takes effect
    assign w_ras_pop = pc_set_i && (pc_mux_i == PC_RAS) && !stall_if_i
                       && !clear_if_i && !w_ras_empty;

    // Next-PC priority: clear, stall, redirect, prediction, sequential, hold
    always_comb begin
        w_pc_next = r_pc;
        if (clear_if_i) begin
            w_pc_next = CLEAR_PC;
        end else if (stall_if_i) begin
            w_pc_next = r_pc;
        end else if (pc_set_i) begin
            case (pc_mux_i)
                PC_BOOT:    w_pc_next = boot_addr_i;
                PC_JUMP:    w_pc_next = jump_target_id_i;
                PC_BRANCH:  w_pc_next = branch_target_ex_i;
                PC_EX_INCR: w_pc_next = pc_incr(pc_ex_i);
                PC_RAS:     w_pc_next = w_ras_empty ? w_pc_incr : w_ras_top;
                default:    w_pc_next = r_pc;
            endcase
        end else if (w_fetch_fire) begin
            w_pc_next = w_pred_cond ? btb_target_i : w_pc_incr;
        end
    end

    // PC register; an ungranted request keeps its address until the grant arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    return_address_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push_i),
        .push_addr (ras_push_addr_i),
        .pop       (w_ras_pop),
        .flush     (ras_flush_i),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full)
    );

    // Output drive; the prediction flag is suppressed by any higher-priority cause
    always_comb begin
        fetch_req_o            = w_fetch_req;
        pc_if_o                = r_pc;
        branch_prediction_if_o = w_pred_cond && !pc_set_i && !stall_if_i && !clear_if_i;
        ras_top_o              = w_ras_top;
        ras_empty_o            = w_ras_empty;
        ras_full_o             = w_ras_full;
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - scoreboard testbench for pc_gen_unit
module tb_pc_gen_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if, clear_if, pc_set;
    logic [3:0]  pc_mux;
    logic [31:0] boot_addr, jump_target, branch_target, pc_ex;
    logic        btb_hit, bht_taken;
    logic [31:0] btb_target;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_flush, fetch_gnt;

    logic        m_req, m_pf, m_empty, m_full;
    logic [31:0] m_pc, m_top;
    logic        z_req, z_pf, z_empty, z_full;
    logic [31:0] z_pc, z_top;
    logic        b_req, b_pf, b_empty, b_full;
    logic [31:0] b_pc, b_top;

    always #5 clk = ~clk;

    pc_gen_unit #(.PRED_MODE(1), .RAS_DEPTH(4), .RESET_PC(32'h100), .CLEAR_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_if_i(stall_if), .clear_if_i(clear_if),
        .pc_set_i(pc_set), .pc_mux_i(pc_mux), .boot_addr_i(boot_addr),
        .jump_target_id_i(jump_target), .branch_target_ex_i(branch_target), .pc_ex_i(pc_ex),
        .btb_hit_i(btb_hit), .btb_target_i(btb_target), .bht_taken_i(bht_taken),
        .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr), .ras_flush_i(ras_flush),
        .fetch_gnt_i(fetch_gnt), .fetch_req_o(m_req), .pc_if_o(m_pc),
        .branch_prediction_if_o(m_pf), .ras_top_o(m_top), .ras_empty_o(m_empty), .ras_full_o(m_full));

    pc_gen_unit #(.PRED_MODE(0), .RAS_DEPTH(4), .RESET_PC(32'h100), .CLEAR_PC(32'h0)) u_dut_m0 (
        .clk(clk), .rst_n(rst_n), .stall_if_i(stall_if), .clear_if_i(clear_if),
        .pc_set_i(pc_set), .pc_mux_i(pc_mux), .boot_addr_i(boot_addr),
        .jump_target_id_i(jump_target), .branch_target_ex_i(branch_target), .pc_ex_i(pc_ex),
        .btb_hit_i(btb_hit), .btb_target_i(btb_target), .bht_taken_i(bht_taken),
        .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr), .ras_flush_i(ras_flush),
        .fetch_gnt_i(fetch_gnt), .fetch_req_o(z_req), .pc_if_o(z_pc),
        .branch_prediction_if_o(z_pf), .ras_top_o(z_top), .ras_empty_o(z_empty), .ras_full_o(z_full));

    pc_gen_unit #(.PRED_MODE(2), .RAS_DEPTH(4), .RESET_PC(32'h100), .CLEAR_PC(32'h0)) u_dut_m2 (
        .clk(clk), .rst_n(rst_n), .stall_if_i(stall_if), .clear_if_i(clear_if),
        .pc_set_i(pc_set), .pc_mux_i(pc_mux), .boot_addr_i(boot_addr),
        .jump_target_id_i(jump_target), .branch_target_ex_i(branch_target), .pc_ex_i(pc_ex),
        .btb_hit_i(btb_hit), .btb_target_i(btb_target), .bht_taken_i(bht_taken),
        .ras_push_i(ras_push), .ras_push_addr_i(ras_push_addr), .ras_flush_i(ras_flush),
        .fetch_gnt_i(fetch_gnt), .fetch_req_o(b_req), .pc_if_o(b_pc),
        .branch_prediction_if_o(b_pf), .ras_top_o(b_top), .ras_empty_o(b_empty), .ras_full_o(b_full));

    // kind 0: a=pc b=req c=pf; kind 1: a=top b=empty c=full; kind 2: a=pc0 b=pf0 d=pc2 e=pf2
    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] a;
        logic        b;
        logic        c;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic exp_pc(input string name, input logic [31:0] pc, input logic req, input logic pf);
        exp_t e;
        e.cyc = cycle; e.kind = 0; e.name = name; e.a = pc; e.b = req; e.c = pf; e.d = '0; e.e = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_ras(input string name, input logic [31:0] top, input logic empty, input logic full);
        exp_t e;
        e.cyc = cycle; e.kind = 1; e.name = name; e.a = top; e.b = empty; e.c = full; e.d = '0; e.e = 1'b0;
        sb.push_back(e);
    endtask

    task automatic exp_alt(input string name, input logic [31:0] pc0, input logic pf0,
                           input logic [31:0] pc2, input logic pf2);
        exp_t e;
        e.cyc = cycle; e.kind = 2; e.name = name; e.a = pc0; e.b = pf0; e.c = 1'b0; e.d = pc2; e.e = pf2;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        bit ok;
        n_tests++;
        ok = (e.cyc == cycle);
        case (e.kind)
            0: begin
                ok = ok && (m_pc === e.a) && (m_req === e.b) && (m_pf === e.c);
                if (!ok) $display("FAIL %s: got pc=%h req=%b pf=%b, expected pc=%h req=%b pf=%b",
                                  e.name, m_pc, m_req, m_pf, e.a, e.b, e.c);
            end
            1: begin
                ok = ok && (m_top === e.a) && (m_empty === e.b) && (m_full === e.c);
                if (!ok) $display("FAIL %s: got top=%h empty=%b full=%b, expected top=%h empty=%b full=%b",
                                  e.name, m_top, m_empty, m_full, e.a, e.b, e.c);
            end
            default: begin
                ok = ok && (z_pc === e.a) && (z_pf === e.b) && (b_pc === e.d) && (b_pf === e.e);
                if (!ok) $display("FAIL %s: got m0 pc=%h pf=%b m2 pc=%h pf=%b, expected m0 pc=%h pf=%b m2 pc=%h pf=%b",
                                  e.name, z_pc, z_pf, b_pc, b_pf, e.a, e.b, e.d, e.e);
            end
        endcase
        if (!ok) n_fail++;
    endtask

    // Monitor: every expectation due in this cycle is compared at the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycle) begin
            check(sb.pop_front());
        end
    end

    task automatic idle_inputs();
        stall_if = 1'b0; clear_if = 1'b0; pc_set = 1'b0; pc_mux = PC_BOOT;
        btb_hit = 1'b0; bht_taken = 1'b0; ras_push = 1'b0; ras_flush = 1'b0; fetch_gnt = 1'b1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic redirect(input logic [3:0] src);
        pc_set = 1'b1;
        pc_mux = src;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        boot_addr = 32'h0; jump_target = 32'h0; branch_target = 32'h0; pc_ex = 32'h0;
        btb_target = 32'h0; ras_push_addr = 32'h0;

        // Reset and boot
        nxt(); nxt();
        exp_pc("reset_pc", 32'h100, 1'b0, 1'b0);
        exp_ras("reset_ras", 32'h0, 1'b1, 1'b0);
        nxt(); rst_n = 1'b1;
        exp_pc("boot_hold", 32'h100, 1'b0, 1'b0);
        nxt(); exp_pc("run_first", 32'h100, 1'b1, 1'b0);
        nxt(); exp_pc("seq_104", 32'h104, 1'b1, 1'b0);
        nxt(); exp_pc("seq_108", 32'h108, 1'b1, 1'b0);
        jump_target = 32'h20; redirect(PC_JUMP);

        // Grant held low for three cycles at 0x20
        nxt(); fetch_gnt = 1'b0; exp_pc("hold_g0", 32'h20, 1'b1, 1'b0);
        nxt(); fetch_gnt = 1'b0; exp_pc("hold_g1", 32'h20, 1'b1, 1'b0);
        nxt(); fetch_gnt = 1'b0; exp_pc("hold_g2", 32'h20, 1'b1, 1'b0);
        nxt(); exp_pc("hold_g3", 32'h20, 1'b1, 1'b0);
        nxt(); exp_pc("gnt_24", 32'h24, 1'b1, 1'b0);
        branch_target = 32'h40; redirect(PC_BRANCH);

        // Prediction modes
        nxt(); btb_hit = 1'b1; bht_taken = 1'b0; btb_target = 32'h80;
        exp_pc("pred_m1", 32'h40, 1'b1, 1'b1);
        exp_alt("pred_m0_m2", 32'h40, 1'b0, 32'h40, 1'b0);
        nxt(); btb_hit = 1'b1; bht_taken = 1'b1; btb_target = 32'hC0;
        exp_pc("pred_80", 32'h80, 1'b1, 1'b1);
        exp_alt("pred_bht", 32'h44, 1'b0, 32'h44, 1'b1);
        nxt(); exp_pc("pred_c0", 32'hC0, 1'b1, 1'b0);
        exp_alt("pred_after", 32'h48, 1'b0, 32'hC0, 1'b0);
        jump_target = 32'h200; redirect(PC_JUMP);

        // RAS fill past capacity, then drain through PC_RAS redirects
        nxt(); exp_pc("ras_jump", 32'h200, 1'b1, 1'b0);
        ras_push = 1'b1; ras_push_addr = 32'h10;
        nxt(); exp_ras("ras_push1", 32'h10, 1'b0, 1'b0);
        ras_push = 1'b1; ras_push_addr = 32'h14;
        nxt(); ras_push = 1'b1; ras_push_addr = 32'h18;
        nxt(); ras_push = 1'b1; ras_push_addr = 32'h1C;
        nxt(); ras_push = 1'b1; ras_push_addr = 32'h20;
        nxt(); exp_ras("ras_full", 32'h20, 1'b0, 1'b1); redirect(PC_RAS);
        nxt(); exp_pc("ras_pop1", 32'h20, 1'b1, 1'b0); redirect(PC_RAS);
        nxt(); exp_pc("ras_pop2", 32'h1C, 1'b1, 1'b0); redirect(PC_RAS);
        nxt(); exp_pc("ras_pop3", 32'h18, 1'b1, 1'b0); redirect(PC_RAS);
        nxt(); exp_pc("ras_pop4", 32'h14, 1'b1, 1'b0);
        exp_ras("ras_drained", 32'h0, 1'b1, 1'b0);
        jump_target = 32'h50; redirect(PC_JUMP);
        nxt(); exp_pc("ras_at_50", 32'h50, 1'b1, 1'b0); redirect(PC_RAS);
        nxt(); exp_pc("ras_empty_seq", 32'h54, 1'b1, 1'b0);
        exp_ras("ras_still_empty", 32'h0, 1'b1, 1'b0);
        jump_target = 32'h300; redirect(PC_JUMP);
        ras_push = 1'b1; ras_push_addr = 32'h30;

        // Priority: clear beats stall beats redirect; pop suppressed
        nxt(); exp_ras("prio_top", 32'h30, 1'b0, 1'b0);
        clear_if = 1'b1; stall_if = 1'b1; redirect(PC_RAS); btb_hit = 1'b1; btb_target = 32'h80;
        exp_pc("prio_pre", 32'h300, 1'b0, 1'b0);
        nxt(); exp_pc("prio_clear", 32'h0, 1'b1, 1'b0);
        exp_ras("prio_nopop", 32'h30, 1'b0, 1'b0);
        ras_push = 1'b1; ras_push_addr = 32'h44; redirect(PC_RAS);
        nxt(); exp_pc("pushpop_pc", 32'h30, 1'b1, 1'b0);
        exp_ras("pushpop_top", 32'h44, 1'b0, 1'b0);
        redirect(PC_RAS);
        nxt(); exp_pc("pushpop_cnt", 32'h44, 1'b1, 1'b0);
        exp_ras("pushpop_empty", 32'h0, 1'b1, 1'b0);
        ras_push = 1'b1; ras_push_addr = 32'h60; ras_flush = 1'b1;
        nxt(); exp_pc("flush_pc", 32'h48, 1'b1, 1'b0);
        exp_ras("flush_wins", 32'h0, 1'b1, 1'b0);
        jump_target = 32'hFFFF_FFFC; redirect(PC_JUMP);

        // Wrap-around and asynchronous reset
        nxt(); exp_pc("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
        ras_push = 1'b1; ras_push_addr = 32'h70;
        nxt(); exp_pc("wrap_0", 32'h0, 1'b1, 1'b0);
        exp_ras("pre_rst_ras", 32'h70, 1'b0, 1'b0);
        nxt(); #1 rst_n = 1'b0; #1;
        exp_pc("async_rst", 32'h100, 1'b0, 1'b0);
        exp_ras("async_rst_ras", 32'h0, 1'b1, 1'b0);

        nxt(); nxt();
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
